axis_rr_arbiter: RTL

- Packet-granular round-robin arbiter that merges SLAVE_NR AXI-Stream sources onto one AXI-Stream master port.
- Grant is held from the first beat to the tlast beat of a packet, then passes to the next requester in round-robin order.
- Output is a registered stage that carries the source index on m_axis_tid; it sits ahead of the shared downstream datapath (delay lines, DMA, packetizers).

---
 rtl/axis_rr_arbiter.sv | 126 ++++++++++++
 1 files changed

// File: rtl/axis_rr_arbiter.sv
// Packet-granular round-robin merge of SLAVE_NR AXI-Stream sources
// onto one registered master port tagged with the source index.
module axis_rr_arbiter #(
    parameter int  AXIS_DATA_WIDTH = 64,
    parameter int  SLAVE_NR        = 4,
    localparam int ID_WIDTH        = $clog2(SLAVE_NR),
    localparam int STRB_WIDTH      = AXIS_DATA_WIDTH / 8
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic [SLAVE_NR-1:0]            s_axis_tvalid,
    input  logic [SLAVE_NR*AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [SLAVE_NR*STRB_WIDTH-1:0] s_axis_tstrb,
    input  logic [SLAVE_NR-1:0]            s_axis_tlast,
    output logic [SLAVE_NR-1:0]            s_axis_tready,
    output logic                           m_axis_tvalid,
    output logic [AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [STRB_WIDTH-1:0]          m_axis_tstrb,
    output logic                           m_axis_tlast,
    output logic [ID_WIDTH-1:0]            m_axis_tid,
    input  logic                           m_axis_tready
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                   state_q, state_d;
    logic [ID_WIDTH-1:0]      grant_q, grant_d;
    logic [ID_WIDTH-1:0]      last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0]      winner;
    logic [ID_WIDTH-1:0]      idx;
    logic                     out_free;
    logic                     accept;
    logic                     sel_valid;
    logic                     sel_last;
    logic [AXIS_DATA_WIDTH-1:0] sel_data;
    logic [STRB_WIDTH-1:0]    sel_strb;

    // Walk from farthest to nearest so the closest requester after
    // last_grant overwrites the others.
    always_comb begin
        winner = last_grant_q;
        idx    = '0;
        for (int k = SLAVE_NR; k >= 1; k--) begin
            idx = ID_WIDTH'((int'(last_grant_q) + k) % SLAVE_NR);
            if (s_axis_tvalid[idx])
                winner = idx;
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        for (int i = 0; i < SLAVE_NR; i++) begin
            if (grant_q == ID_WIDTH'(i)) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
                sel_strb  = s_axis_tstrb[i*STRB_WIDTH +: STRB_WIDTH];
            end
        end
    end

    assign out_free = !m_axis_tvalid || m_axis_tready;
    assign accept   = (state_q == BUSY) && sel_valid && out_free;

    // Ready never looks at tvalid, only at grant and output occupancy.
    always_comb begin
        s_axis_tready = '0;
        if (state_q == BUSY)
            s_axis_tready[grant_q] = out_free;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_WIDTH'(SLAVE_NR - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tstrb  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tid    <= '0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tstrb  <= sel_strb;
            m_axis_tlast  <= sel_last;
            m_axis_tid    <= grant_q;
        end else if (m_axis_tvalid && m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

endmodule
